// File: rtl/mrsc_pkg.sv
// Shared definitions for the MRSC codeword checker: field offsets, codeword type
// and the redundancy function used to recompute the stored check bits.
package mrsc_pkg;

    localparam int unsigned DATA_LSB = 32'd16;
    localparam int unsigned DI_LSB   = 32'd12;
    localparam int unsigned P_LSB    = 32'd8;
    localparam int unsigned X_LSB    = 32'd0;
    localparam int unsigned DATA_W   = 32'd16;
    localparam int unsigned RED_W    = 32'd16;

    typedef logic [31:0] mrsc_cw_t;

    // Result is laid out exactly like codeword[15:0]: DI_1..4, P1..4, then XA..XD pairs.
    function automatic logic [15:0] mrsc_redundancy(input logic [15:0] d);
        logic [3:0] w_di;
        logic [3:0] w_p;
        logic [7:0] w_x;
        w_di = {d[0] ^ d[5] ^ d[8]  ^ d[13],
                d[1] ^ d[4] ^ d[9]  ^ d[12],
                d[2] ^ d[7] ^ d[10] ^ d[15],
                d[3] ^ d[6] ^ d[11] ^ d[14]};
        w_p  = {d[0] ^ d[4] ^ d[8]  ^ d[12],
                d[1] ^ d[5] ^ d[9]  ^ d[13],
                d[2] ^ d[6] ^ d[10] ^ d[14],
                d[3] ^ d[7] ^ d[11] ^ d[15]};
        w_x  = {d[0]  ^ d[2],  d[1]  ^ d[3],
                d[4]  ^ d[6],  d[5]  ^ d[7],
                d[8]  ^ d[10], d[9]  ^ d[11],
                d[12] ^ d[14], d[13] ^ d[15]};
        return {w_di, w_p, w_x};
    endfunction

endpackage

// File: rtl/mrsc_err_stats.sv
// Error statistics: saturating error counter and sticky capture of the first
// failing codeword; clear overrides any coincident update.
module mrsc_err_stats
    import mrsc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_xfer,
    input  logic             i_error,
    input  mrsc_cw_t         i_codeword,
    output logic [CNT_W-1:0] o_count,
    output logic             o_first_valid,
    output mrsc_cw_t         o_first_codeword
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;
    logic             r_first_valid;
    mrsc_cw_t         r_first_codeword;

    // Counter and first-error capture, updated on each erroneous output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count          <= {CNT_W{1'b0}};
            r_first_valid    <= 1'b0;
            r_first_codeword <= 32'h0000_0000;
        end else if (i_clear) begin
            r_count          <= {CNT_W{1'b0}};
            r_first_valid    <= 1'b0;
            r_first_codeword <= 32'h0000_0000;
        end else if (i_xfer && i_error) begin
            if (r_count != CNT_MAX) begin
                r_count <= r_count + CNT_ONE;
            end
            if (!r_first_valid) begin
                r_first_valid    <= 1'b1;
                r_first_codeword <= i_codeword;
            end
        end
    end

    assign o_count          = r_count;
    assign o_first_valid    = r_first_valid;
    assign o_first_codeword = r_first_codeword;

endmodule

// File: rtl/mrsc_codeword_checker.sv
// Two-stage elastic checker: recomputes MRSC redundancy, emits the syndrome and
// error flag, and feeds the error statistics block on each output transfer.
module mrsc_codeword_checker
    import mrsc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [15:0]      out_syndrome,
    output logic             out_error,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [31:0]      first_err_codeword
);

    logic        r_s1_v;
    mrsc_cw_t    r_s1_cw;
    logic [15:0] r_s1_red;
    logic        r_s2_v;
    logic [15:0] r_out_data;
    logic [15:0] r_out_syn;
    logic        r_out_err;
    mrsc_cw_t    r_s2_cw;

    logic        w_s2_ld;
    logic        w_s1_ld;
    logic        w_out_xfer;
    logic [15:0] w_syn;

    // A stage may load when it is empty or its contents leave this cycle.
    assign w_s2_ld    = !r_s2_v || out_ready;
    assign w_s1_ld    = !r_s1_v || w_s2_ld;
    assign w_out_xfer = r_s2_v && out_ready;
    assign w_syn      = r_s1_cw[X_LSB +: RED_W] ^ r_s1_red;

    // Stage 1: capture codeword and its recomputed redundancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_cw  <= 32'h0000_0000;
            r_s1_red <= 16'h0000;
        end else if (w_s1_ld) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_cw  <= in_codeword;
                r_s1_red <= mrsc_redundancy(in_codeword[DATA_LSB +: DATA_W]);
            end
        end
    end

    // Stage 2: registered result, held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v     <= 1'b0;
            r_out_data <= 16'h0000;
            r_out_syn  <= 16'h0000;
            r_out_err  <= 1'b0;
            r_s2_cw    <= 32'h0000_0000;
        end else if (w_s2_ld) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_out_data <= r_s1_cw[DATA_LSB +: DATA_W];
                r_out_syn  <= w_syn;
                r_out_err  <= |w_syn;
                r_s2_cw    <= r_s1_cw;
            end
        end
    end

    mrsc_err_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_clear          (clear),
        .i_xfer           (w_out_xfer),
        .i_error          (r_out_err),
        .i_codeword       (r_s2_cw),
        .o_count          (err_count),
        .o_first_valid    (first_err_valid),
        .o_first_codeword (first_err_codeword)
    );

    assign in_ready     = w_s1_ld;
    assign out_valid    = r_s2_v;
    assign out_data     = r_out_data;
    assign out_syndrome = r_out_syn;
    assign out_error    = r_out_err;

endmodule
